// File: rtl/instr_encoder.sv
// Packs instruction fields into 32-bit words, queues them in a 4-entry FIFO and
// streams them to instruction memory at consecutive word addresses.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [31:0] BaseAddr,
  input  logic        InValid,
  output logic        InReady,
  input  logic        InLast,
  input  logic [3:0]  Cond,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic [3:0]  Rn,
  input  logic [3:0]  Rd,
  input  logic [11:0] Src2,
  input  logic [23:0] Imm24,
  output logic        MemWE,
  input  logic        MemReady,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWD,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [15:0] WordCount
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

  state_t      r_state;
  logic [31:0] r_fifo [4];
  logic [1:0]  r_rd_ptr;
  logic [1:0]  r_wr_ptr;
  logic [2:0]  r_count;
  logic [31:0] r_addr;
  logic [15:0] r_word_count;
  logic        r_err;

  logic        w_full;
  logic        w_empty;
  logic        w_xfer;
  logic        w_illegal;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_word;

  assign w_full    = (r_count == 3'd4);
  assign w_empty   = (r_count == 3'd0);
  assign InReady   = (r_state == StRun) && !w_full;
  assign w_xfer    = InValid && InReady;
  assign w_illegal = (Op == 2'b11);
  assign w_push    = w_xfer && !w_illegal;
  assign MemWE     = !w_empty && ((r_state == StRun) || (r_state == StDrain));
  assign w_pop     = MemWE && MemReady;

  // Branches carry only the top two Funct bits ahead of the 24-bit offset.
  always_comb begin
    w_word = {Cond, Op, Funct, Rn, Rd, Src2};
    if (Op == 2'b10) begin
      w_word = {Cond, 2'b10, Funct[5:4], Imm24};
    end
  end

  assign MemWD     = w_empty ? 32'd0 : r_fifo[r_rd_ptr];
  assign MemAddr   = r_addr;
  assign WordCount = r_word_count;
  assign Err       = r_err;
  assign Busy      = (r_state != StIdle);
  assign Done      = (r_state == StDone);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_rd_ptr     <= 2'd0;
      r_wr_ptr     <= 2'd0;
      r_count      <= 3'd0;
      r_addr       <= 32'd0;
      r_word_count <= 16'd0;
      r_err        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_fifo[i] <= 32'd0;
      end
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_word;
        r_wr_ptr         <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + 2'd1;
        r_addr       <= r_addr + 32'd4;
        r_word_count <= r_word_count + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_xfer && w_illegal) begin
        r_err <= 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          if (Start) begin
            r_state      <= StRun;
            r_addr       <= {BaseAddr[31:2], 2'b00};
            r_word_count <= 16'd0;
            r_err        <= 1'b0;
          end
        end
        StRun: begin
          if (w_xfer && InLast) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (w_empty || ((r_count == 3'd1) && w_pop)) begin
            r_state <= StDone;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written
// corner sequences and random programs against a queue-based reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [31:0] BaseAddr;
  logic        InValid;
  logic        InReady;
  logic        InLast;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rn;
  logic [3:0]  Rd;
  logic [11:0] Src2;
  logic [23:0] Imm24;
  logic        MemWE;
  logic        MemReady;
  logic [31:0] MemAddr;
  logic [31:0] MemWD;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic [15:0] WordCount;

  instr_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .BaseAddr (BaseAddr),
    .InValid  (InValid),
    .InReady  (InReady),
    .InLast   (InLast),
    .Cond     (Cond),
    .Op       (Op),
    .Funct    (Funct),
    .Rn       (Rn),
    .Rd       (Rd),
    .Src2     (Src2),
    .Imm24    (Imm24),
    .MemWE    (MemWE),
    .MemReady (MemReady),
    .MemAddr  (MemAddr),
    .MemWD    (MemWD),
    .Busy     (Busy),
    .Done     (Done),
    .Err      (Err),
    .WordCount(WordCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
  } fld_t;

  typedef struct {
    fld_t        f;
    logic [31:0] base;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
  } vec_t;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;
  logic [31:0] last_wd;
  logic [31:0] last_addr;
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endtask

  // Reference encoding built from field weights rather than concatenation.
  function automatic logic [31:0] encode(input fld_t f);
    int unsigned w;
    if (f.op == 2'd2) begin
      w = 32'(f.cond) * 32'h1000_0000 + 32'd2 * 32'h0400_0000 +
          (32'(f.funct) / 32'd16) * 32'h0100_0000 + 32'(f.imm24);
    end else begin
      w = 32'(f.cond) * 32'h1000_0000 + 32'(f.op) * 32'h0400_0000 +
          32'(f.funct) * 32'h0010_0000 + 32'(f.rn) * 32'h0001_0000 +
          32'(f.rd) * 32'h0000_1000 + 32'(f.src2);
    end
    return w;
  endfunction

  function automatic fld_t rand_fld(input bit allow_bad);
    fld_t f;
    f.cond  = 4'($urandom);
    f.op    = (allow_bad && $urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    f.funct = 6'($urandom);
    f.rn    = 4'($urandom);
    f.rd    = 4'($urandom);
    f.src2  = 12'($urandom);
    f.imm24 = 24'($urandom);
    return f;
  endfunction

  // Scoreboard: check writes against the queue, then record accepted words.
  always @(negedge clk) begin
    if (MemWE && MemReady) begin
      if (exp_q.size() == 0) begin
        check("unexpected write", {31'd0, MemWE}, 32'd0);
      end else begin
        check("write data", MemWD, exp_q.pop_front());
        check("write addr", MemAddr, exp_addr);
        exp_addr  = exp_addr + 32'd4;
        last_wd   = MemWD;
        last_addr = MemAddr;
      end
    end
    if (InValid && InReady && Op != 2'd3) begin
      exp_q.push_back(encode('{Cond, Op, Funct, Rn, Rd, Src2, Imm24}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) MemReady = 1'($urandom_range(0, 1));
  endtask

  task automatic set_fields(input fld_t f);
    Cond = f.cond; Op = f.op; Funct = f.funct; Rn = f.rn; Rd = f.rd;
    Src2 = f.src2; Imm24 = f.imm24;
  endtask

  task automatic start_prog(input logic [31:0] base);
    Start    = 1'b1;
    BaseAddr = base;
    exp_addr = (base / 32'd4) * 32'd4;
    tick();
    Start = 1'b0;
  endtask

  task automatic send(input fld_t f, input bit last);
    bit ok = 1'b0;
    set_fields(f);
    InValid = 1'b1;
    InLast  = last;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      ok = InReady;
      tick();
      if (ok) break;
    end
    InValid = 1'b0;
    InLast  = 1'b0;
    check("send accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int w = 0; w < 300 && !seen; w++) begin
      @(negedge clk);
      seen = Done;
      tick();
    end
    check("done pulse", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check("done one cycle", {31'd0, Done}, 32'd0);
    check("idle not busy", {31'd0, Busy}, 32'd0);
    tick();
  endtask

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fld_t f;
    int   n_words;
    bit   bad;
    bit   we_seen;

    vecs[0] = '{'{4'hE, 2'd0, 6'h08, 4'h1, 4'h2, 12'h003, 24'h0}, 32'h103, 32'h100, 32'hE081_2003};
    vecs[1] = '{'{4'hA, 2'd2, 6'h20, 4'h0, 4'h0, 12'h000, 24'hFF_FFFE}, 32'h0, 32'h0, 32'hAAFF_FFFE};
    vecs[2] = '{'{4'h1, 2'd1, 6'h3F, 4'hF, 4'h0, 12'hABC, 24'h0}, 32'hFFFF_FFFE, 32'hFFFF_FFFC,
                32'h17FF_0ABC};
    vecs[3] = '{'{4'h0, 2'd2, 6'h1F, 4'hF, 4'hF, 12'hFFF, 24'h12_3456}, 32'h4001, 32'h4000,
                32'h0912_3456};
    vecs[4] = '{'{4'hF, 2'd0, 6'h00, 4'h0, 4'h0, 12'h000, 24'h0}, 32'h8, 32'h8, 32'hF000_0000};

    reset = 1'b1; Start = 1'b0; BaseAddr = 32'd0; InValid = 1'b0; InLast = 1'b0;
    MemReady = 1'b1; exp_addr = 32'd0; last_wd = 32'd0; last_addr = 32'd0;
    set_fields(vecs[4].f);
    #12;
    check("reset InReady", {31'd0, InReady}, 32'd0);
    check("reset MemWE", {31'd0, MemWE}, 32'd0);
    check("reset MemAddr", MemAddr, 32'd0);
    check("reset Busy", {31'd0, Busy}, 32'd0);
    check("reset WordCount", {16'd0, WordCount}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Directed single-instruction programs.
    for (int i = 0; i < 5; i++) begin
      start_prog(vecs[i].base);
      send(vecs[i].f, 1'b1);
      @(negedge clk);
      check($sformatf("vec%0d next-cycle MemWE", i), {31'd0, MemWE}, 32'd1);
      tick();
      wait_done();
      check($sformatf("vec%0d MemWD", i), last_wd, vecs[i].exp_wd);
      check($sformatf("vec%0d MemAddr", i), last_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d WordCount", i), {16'd0, WordCount}, 32'd1);
      check($sformatf("vec%0d Err", i), {31'd0, Err}, 32'd0);
    end

    // Backpressure: FIFO fills at 4, fifth word waits until memory drains.
    MemReady = 1'b0;
    start_prog(32'h2000);
    for (int k = 0; k < 4; k++) send(rand_fld(1'b0), 1'b0);
    set_fields(rand_fld(1'b0));
    InValid = 1'b1;
    InLast  = 1'b1;
    @(negedge clk);
    check("full InReady", {31'd0, InReady}, 32'd0);
    check("stalled MemWE", {31'd0, MemWE}, 32'd1);
    tick();
    @(negedge clk);
    check("stalled InReady", {31'd0, InReady}, 32'd0);
    check("stalled WordCount", {16'd0, WordCount}, 32'd0);
    tick();
    MemReady = 1'b1;
    send('{Cond, Op, Funct, Rn, Rd, Src2, Imm24}, 1'b1);
    wait_done();
    check("bp WordCount", {16'd0, WordCount}, 32'd5);
    check("bp last addr", last_addr, 32'h2010);
    check("bp queue drained", exp_q.size(), 32'd0);

    // Illegal Op as the last instruction.
    start_prog(32'h300);
    f = rand_fld(1'b0);
    f.op = 2'd3;
    send(f, 1'b1);
    wait_done();
    check("illegal Err", {31'd0, Err}, 32'd1);
    check("illegal WordCount", {16'd0, WordCount}, 32'd0);
    start_prog(32'h300);
    check("Err cleared by Start", {31'd0, Err}, 32'd0);
    send(rand_fld(1'b0), 1'b1);
    wait_done();

    // Start during RUN must not reload the address or count.
    start_prog(32'h400);
    send(rand_fld(1'b0), 1'b0);
    Start    = 1'b1;
    BaseAddr = 32'h800;
    tick();
    Start = 1'b0;
    send(rand_fld(1'b0), 1'b1);
    wait_done();
    check("restart WordCount", {16'd0, WordCount}, 32'd2);
    check("restart last addr", last_addr, 32'h404);

    // Reset with words queued.
    MemReady = 1'b0;
    start_prog(32'h500);
    for (int k = 0; k < 3; k++) send(rand_fld(1'b0), 1'b0);
    reset = 1'b1;
    #1;
    check("rst InReady", {31'd0, InReady}, 32'd0);
    check("rst MemWE", {31'd0, MemWE}, 32'd0);
    check("rst MemAddr", MemAddr, 32'd0);
    check("rst MemWD", MemWD, 32'd0);
    check("rst Busy", {31'd0, Busy}, 32'd0);
    check("rst Done", {31'd0, Done}, 32'd0);
    check("rst WordCount", {16'd0, WordCount}, 32'd0);
    check("rst Err", {31'd0, Err}, 32'd0);
    exp_q.delete();
    tick();
    reset    = 1'b0;
    MemReady = 1'b1;
    we_seen  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (MemWE) we_seen = 1'b1;
      tick();
    end
    check("no write after reset", {31'd0, we_seen}, 32'd0);

    // Random programs with random memory backpressure.
    for (int p = 0; p < 20; p++) begin
      n_words = 0;
      bad     = 1'b0;
      start_prog($urandom);
      rand_ready = 1'b1;
      for (int k = $urandom_range(1, 8); k > 0; k--) begin
        f = rand_fld(1'b1);
        if (f.op == 2'd3) bad = 1'b1;
        else n_words++;
        send(f, k == 1);
      end
      wait_done();
      rand_ready = 1'b0;
      MemReady   = 1'b1;
      check($sformatf("rand%0d WordCount", p), {16'd0, WordCount}, n_words);
      check($sformatf("rand%0d Err", p), {31'd0, Err}, {31'd0, bad});
      check($sformatf("rand%0d queue drained", p), exp_q.size(), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
